// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle of pipeline-register fields seen by the forwarding/hazard controller.
// The i_/o_ prefixes are from the controller's point of view: the pipeline
// (master) drives the i_ fields and consumes the o_ fields.
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] i_id_ex_rs;
    logic [REG_AW-1:0] i_id_ex_rt;
    logic [REG_AW-1:0] i_id_ex_rd;
    logic              i_id_ex_mem_read;
    logic              i_ex_mem_reg_write;
    logic [REG_AW-1:0] i_ex_mem_rd;
    logic              i_mem_wb_reg_write;
    logic [REG_AW-1:0] i_mem_wb_rd;
    logic [REG_AW-1:0] i_if_id_rs;
    logic [REG_AW-1:0] i_if_id_rt;
    logic              i_if_id_uses_rt;
    logic              i_hold_in;
    logic [1:0]        o_fwd_a;
    logic [1:0]        o_fwd_b;
    logic              o_stall_pc;
    logic              o_stall_ifid;
    logic              o_flush_idex;
    logic [CNT_W-1:0]  o_stall_cycles;

    modport master (
        output i_id_ex_rs, i_id_ex_rt, i_id_ex_rd, i_id_ex_mem_read,
               i_ex_mem_reg_write, i_ex_mem_rd, i_mem_wb_reg_write, i_mem_wb_rd,
               i_if_id_rs, i_if_id_rt, i_if_id_uses_rt, i_hold_in,
        input  o_fwd_a, o_fwd_b, o_stall_pc, o_stall_ifid, o_flush_idex,
               o_stall_cycles
    );

    modport slave (
        input  i_id_ex_rs, i_id_ex_rt, i_id_ex_rd, i_id_ex_mem_read,
               i_ex_mem_reg_write, i_ex_mem_rd, i_mem_wb_reg_write, i_mem_wb_rd,
               i_if_id_rs, i_if_id_rt, i_if_id_uses_rt, i_hold_in,
        output o_fwd_a, o_fwd_b, o_stall_pc, o_stall_ifid, o_flush_idex,
               o_stall_cycles
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Operand A/B forwarding is purely combinational with EX/MEM winning over
// MEM/WB. A load in ID/EX whose target is read by the instruction in IF/ID
// freezes PC and IF/ID and bubbles ID/EX for LOAD_LAT cycles (legal 1..7).
// Stall cycles that actually advance the pipeline are counted, saturating.
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int EXCL_EN  = 1,
    parameter int EXCL_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_ctrl_if.slave   bus
);

    localparam logic [0:0]        ST_IDLE     = 1'b0;
    localparam logic [0:0]        ST_STALL    = 1'b1;
    localparam logic [2:0]        LAT_RELOAD  = 3'(LOAD_LAT - 1);
    localparam logic              MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic              EXCL_ON     = (EXCL_EN != 0);
    localparam logic [REG_AW-1:0] EXCL_IDX    = REG_AW'(EXCL_REG);
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

    // A producer may forward only if it really writes a non-zero register
    // that is not the link register served by its own path.
    function automatic logic writeOk(input logic we, input logic [REG_AW-1:0] rd);
        return we && (rd != '0) && !(EXCL_ON && (rd == EXCL_IDX));
    endfunction

    // The younger producer (EX/MEM) holds the newer value, so it wins.
    function automatic logic [1:0] selectSrc(input logic emHit, input logic wbHit);
        if (emHit) begin
            return 2'b10;
        end else if (wbHit) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    logic        w_em_ok;
    logic        w_wb_ok;
    logic        w_em_hit_a;
    logic        w_wb_hit_a;
    logic        w_em_hit_b;
    logic        w_wb_hit_b;
    logic        w_rs_conflict;
    logic        w_rt_conflict;
    logic        w_haz;
    logic        w_stall;
    logic        w_advance;
    logic        w_cnt_sat;
    logic [0:0]  w_state_nxt;
    logic [2:0]  w_rem_nxt;

    logic [0:0]       r_state;
    logic [2:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cycles;

    assign w_em_ok = writeOk(bus.i_ex_mem_reg_write, bus.i_ex_mem_rd);
    assign w_wb_ok = writeOk(bus.i_mem_wb_reg_write, bus.i_mem_wb_rd);

    assign w_em_hit_a = w_em_ok && (bus.i_ex_mem_rd == bus.i_id_ex_rs);
    assign w_wb_hit_a = w_wb_ok && (bus.i_mem_wb_rd == bus.i_id_ex_rs);
    assign w_em_hit_b = w_em_ok && (bus.i_ex_mem_rd == bus.i_id_ex_rt);
    assign w_wb_hit_b = w_wb_ok && (bus.i_mem_wb_rd == bus.i_id_ex_rt);

    // rt only counts when the ID instruction actually reads it as a source;
    // the link-register exclusion does not apply here since a load result
    // is simply not available yet regardless of its destination.
    assign w_rs_conflict = (bus.i_id_ex_rd == bus.i_if_id_rs);
    assign w_rt_conflict = bus.i_if_id_uses_rt && (bus.i_id_ex_rd == bus.i_if_id_rt);
    assign w_haz = bus.i_id_ex_mem_read && (bus.i_id_ex_rd != '0)
                   && (w_rs_conflict || w_rt_conflict);

    // The first stall cycle comes straight from the hazard; later ones from the FSM.
    assign w_stall   = ((r_state == ST_IDLE) && w_haz) || (r_state == ST_STALL);
    assign w_advance = !bus.i_hold_in;
    assign w_cnt_sat = (r_stall_cycles == CNT_MAX);

    // Forward-select outputs.
    always_comb begin
        bus.o_fwd_a = selectSrc(w_em_hit_a, w_wb_hit_a);
        bus.o_fwd_b = selectSrc(w_em_hit_b, w_wb_hit_b);
    end

    // Next-state logic: a hazard seen in IDLE arms the remaining stall cycles; STALL counts them down, all frozen by hold.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        if (w_advance) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_haz && MULTI_CYCLE) begin
                        w_state_nxt = ST_STALL;
                        w_rem_nxt   = LAT_RELOAD;
                    end
                end
                ST_STALL: begin
                    w_rem_nxt = r_rem - 3'd1;
                    if (r_rem == 3'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = 3'd0;
                end
            endcase
        end
    end

    // State and remaining-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Saturating performance counter of stall cycles that were not frozen by hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_stall && w_advance && !w_cnt_sat) begin
            r_stall_cycles <= r_stall_cycles + CNT_ONE;
        end
    end

    // All three stall controls move together.
    always_comb begin
        bus.o_stall_pc     = w_stall;
        bus.o_stall_ifid   = w_stall;
        bus.o_flush_idex   = w_stall;
        bus.o_stall_cycles = r_stall_cycles;
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances share one stimulus stream.
// A: LOAD_LAT=3, EXCL_EN=1, CNT_W=16.  B: LOAD_LAT=1, EXCL_EN=0, CNT_W=3.
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic [4:0] idRs;
        logic [4:0] idRt;
        logic [4:0] idRd;
        logic       memRd;
        logic       emWe;
        logic [4:0] emRd;
        logic       wbWe;
        logic [4:0] wbRd;
        logic [4:0] ifRs;
        logic [4:0] ifRt;
        logic       usesRt;
        logic       hold;
        logic       rst;
    } stim_t;

    logic   clk = 1'b0;
    stim_t  drv;
    stim_t  cur;
    int     checks = 0;
    int     failures = 0;
    bit     modelValid = 1'b0;
    int     mRem [2];
    longint mCnt [2];
    int     stallCount;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) ifA ();
    fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(3))  ifB ();

    assign ifA.i_id_ex_rs         = drv.idRs;
    assign ifA.i_id_ex_rt         = drv.idRt;
    assign ifA.i_id_ex_rd         = drv.idRd;
    assign ifA.i_id_ex_mem_read   = drv.memRd;
    assign ifA.i_ex_mem_reg_write = drv.emWe;
    assign ifA.i_ex_mem_rd        = drv.emRd;
    assign ifA.i_mem_wb_reg_write = drv.wbWe;
    assign ifA.i_mem_wb_rd        = drv.wbRd;
    assign ifA.i_if_id_rs         = drv.ifRs;
    assign ifA.i_if_id_rt         = drv.ifRt;
    assign ifA.i_if_id_uses_rt    = drv.usesRt;
    assign ifA.i_hold_in          = drv.hold;

    assign ifB.i_id_ex_rs         = drv.idRs;
    assign ifB.i_id_ex_rt         = drv.idRt;
    assign ifB.i_id_ex_rd         = drv.idRd;
    assign ifB.i_id_ex_mem_read   = drv.memRd;
    assign ifB.i_ex_mem_reg_write = drv.emWe;
    assign ifB.i_ex_mem_rd        = drv.emRd;
    assign ifB.i_mem_wb_reg_write = drv.wbWe;
    assign ifB.i_mem_wb_rd        = drv.wbRd;
    assign ifB.i_if_id_rs         = drv.ifRs;
    assign ifB.i_if_id_rt         = drv.ifRt;
    assign ifB.i_if_id_uses_rt    = drv.usesRt;
    assign ifB.i_hold_in          = drv.hold;

    fwd_hazard_ctrl #(
        .REG_AW(5), .LOAD_LAT(3), .EXCL_EN(1), .EXCL_REG(31), .CNT_W(16)
    ) dutA (
        .clk(clk),
        .rst(drv.rst),
        .bus(ifA.slave)
    );

    fwd_hazard_ctrl #(
        .REG_AW(5), .LOAD_LAT(1), .EXCL_EN(0), .EXCL_REG(31), .CNT_W(3)
    ) dutB (
        .clk(clk),
        .rst(drv.rst),
        .bus(ifB.slave)
    );

    function automatic int latOf(input int k);
        return (k == 0) ? 3 : 1;
    endfunction

    function automatic bit exclOf(input int k);
        return (k == 0);
    endfunction

    function automatic longint maxOf(input int k);
        return (k == 0) ? 65535 : 7;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Forward select straight from the rule: newest valid writer of the source register wins.
    function automatic logic [1:0] modelFwd(input stim_t s, input logic [4:0] src, input bit exclEn);
        bit emOk;
        bit wbOk;
        emOk = s.emWe && (s.emRd != 0) && !(exclEn && s.emRd == 31);
        wbOk = s.wbWe && (s.wbRd != 0) && !(exclEn && s.wbRd == 31);
        if (emOk && s.emRd == src) return 2'b10;
        if (wbOk && s.wbRd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit modelHaz(input stim_t s);
        return s.memRd && (s.idRd != 0)
               && (s.idRd == s.ifRs || (s.usesRt && s.idRd == s.ifRt));
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mRem is the number of stall cycles still owed after the current one.
    always @(posedge clk) begin
        if (drv.rst) begin
            for (int k = 0; k < 2; k++) begin
                mRem[k] = 0;
                mCnt[k] = 0;
            end
            modelValid = 1'b1;
        end else if (!drv.hold) begin
            for (int k = 0; k < 2; k++) begin
                bit st;
                st = (mRem[k] > 0) || modelHaz(drv);
                if (mRem[k] > 0) mRem[k] = mRem[k] - 1;
                else if (modelHaz(drv)) mRem[k] = latOf(k) - 1;
                if (st && mCnt[k] < maxOf(k)) mCnt[k] = mCnt[k] + 1;
            end
        end
    end

    task automatic compareInst(input string tag, input int k,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic spc, input logic sif, input logic fl,
                               input logic [63:0] cnt);
        logic expStall;
        expStall = (mRem[k] > 0) || modelHaz(drv);
        checkOutput({tag, ".fwd_a"}, 64'(fa), 64'(modelFwd(drv, drv.idRs, exclOf(k))));
        checkOutput({tag, ".fwd_b"}, 64'(fb), 64'(modelFwd(drv, drv.idRt, exclOf(k))));
        checkOutput({tag, ".stall_pc"}, 64'(spc), 64'(expStall));
        checkOutput({tag, ".stall_ifid"}, 64'(sif), 64'(expStall));
        checkOutput({tag, ".flush_idex"}, 64'(fl), 64'(expStall));
        checkOutput({tag, ".stall_cycles"}, cnt, 64'(mCnt[k]));
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (modelValid) begin
            compareInst("A", 0, ifA.o_fwd_a, ifA.o_fwd_b, ifA.o_stall_pc,
                        ifA.o_stall_ifid, ifA.o_flush_idex, 64'(ifA.o_stall_cycles));
            compareInst("B", 1, ifB.o_fwd_a, ifB.o_fwd_b, ifB.o_stall_pc,
                        ifB.o_stall_ifid, ifB.o_flush_idex, 64'(ifB.o_stall_cycles));
        end
    end

    // One pipeline cycle: new inputs just after the edge, return at mid-cycle for sampling.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        drv = s;
        @(negedge clk);
    endtask

    initial begin
        drv = idle();
        drv.rst = 1'b1;
        cur = idle();
        cur.rst = 1'b1;
        applyStimulus(cur);
        applyStimulus(cur);
        checkOutput("reset.A.stall_cycles", 64'(ifA.o_stall_cycles), 64'd0);
        checkOutput("reset.A.stall_pc", 64'(ifA.o_stall_pc), 64'd0);
        checkOutput("reset.A.fwd_a", 64'(ifA.o_fwd_a), 64'd0);
        cur.rst = 1'b0;

        // EX/MEM priority over MEM/WB on the same register.
        cur = idle();
        cur.emWe = 1; cur.emRd = 3; cur.wbWe = 1; cur.wbRd = 3; cur.idRs = 3;
        applyStimulus(cur);
        checkOutput("prio.A.fwd_a", 64'(ifA.o_fwd_a), 64'h2);

        // Independent A/B from different stages.
        cur = idle();
        cur.emWe = 1; cur.emRd = 4; cur.wbWe = 1; cur.wbRd = 5; cur.idRs = 5; cur.idRt = 4;
        applyStimulus(cur);
        checkOutput("indep.A.fwd_a", 64'(ifA.o_fwd_a), 64'h1);
        checkOutput("indep.A.fwd_b", 64'(ifA.o_fwd_b), 64'h2);

        // r0 never forwards.
        cur = idle();
        cur.emWe = 1; cur.wbWe = 1;
        applyStimulus(cur);
        checkOutput("r0.A.fwd_a", 64'(ifA.o_fwd_a), 64'h0);
        checkOutput("r0.A.fwd_b", 64'(ifA.o_fwd_b), 64'h0);

        // r31 excluded on A, forwarded on B.
        cur = idle();
        cur.emWe = 1; cur.emRd = 31; cur.wbWe = 1; cur.wbRd = 31; cur.idRs = 31; cur.idRt = 31;
        applyStimulus(cur);
        checkOutput("excl.A.fwd_a", 64'(ifA.o_fwd_a), 64'h0);
        checkOutput("excl.A.fwd_b", 64'(ifA.o_fwd_b), 64'h0);
        checkOutput("excl.B.fwd_a", 64'(ifB.o_fwd_a), 64'h2);

        cur = idle();
        cur.emWe = 1; cur.emRd = 7; cur.wbWe = 1; cur.wbRd = 31; cur.idRs = 31; cur.idRt = 7;
        applyStimulus(cur);
        checkOutput("exclwb.A.fwd_a", 64'(ifA.o_fwd_a), 64'h0);
        checkOutput("exclwb.B.fwd_a", 64'(ifB.o_fwd_a), 64'h1);

        cur = idle();
        cur.emRd = 9; cur.wbRd = 9; cur.idRs = 9; cur.idRt = 9;
        applyStimulus(cur);

        // Load-use on rs: A stalls exactly 3 cycles, B exactly 1.
        stallCount = 0;
        cur = idle();
        cur.memRd = 1; cur.idRd = 8; cur.ifRs = 8;
        applyStimulus(cur);
        stallCount += int'(ifA.o_stall_pc);
        cur = idle();
        applyStimulus(cur);
        checkOutput("lat1.B.stall_pc", 64'(ifB.o_stall_pc), 64'd0);
        stallCount += int'(ifA.o_stall_pc);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(cur);
            stallCount += int'(ifA.o_stall_pc);
        end
        checkOutput("lat3.A.stall_len", 64'(stallCount), 64'd3);
        checkOutput("lat3.A.stall_cycles", 64'(ifA.o_stall_cycles), 64'd3);
        checkOutput("lat1.B.stall_cycles", 64'(ifB.o_stall_cycles), 64'd1);

        // Same hazard with two hold cycles in the middle.
        stallCount = 0;
        for (int i = 0; i < 8; i++) begin
            cur = idle();
            if (i == 0) begin
                cur.memRd = 1; cur.idRd = 8; cur.ifRs = 8;
            end
            cur.hold = (i == 1 || i == 2);
            applyStimulus(cur);
            stallCount += int'(ifA.o_stall_pc);
        end
        checkOutput("hold.A.stall_len", 64'(stallCount), 64'd5);
        checkOutput("hold.A.stall_cycles", 64'(ifA.o_stall_cycles), 64'd6);
        checkOutput("hold.B.stall_cycles", 64'(ifB.o_stall_cycles), 64'd2);

        // rt conflicts only when rt is a source; rd=0 never hazards.
        cur = idle();
        cur.memRd = 1; cur.idRd = 12; cur.ifRs = 1; cur.ifRt = 12;
        applyStimulus(cur);
        checkOutput("rtunused.A.stall_pc", 64'(ifA.o_stall_pc), 64'd0);
        cur.usesRt = 1;
        applyStimulus(cur);
        checkOutput("rtused.A.stall_pc", 64'(ifA.o_stall_pc), 64'd1);
        cur = idle();
        for (int i = 0; i < 3; i++) applyStimulus(cur);
        cur.memRd = 1; cur.idRd = 0; cur.ifRs = 0;
        applyStimulus(cur);
        checkOutput("rd0.A.stall_pc", 64'(ifA.o_stall_pc), 64'd0);

        // Hold while a hazard is pending in IDLE, then release.
        cur = idle();
        cur.memRd = 1; cur.idRd = 6; cur.ifRt = 6; cur.usesRt = 1; cur.hold = 1;
        applyStimulus(cur);
        cur.hold = 0;
        applyStimulus(cur);
        cur = idle();
        for (int i = 0; i < 3; i++) applyStimulus(cur);

        // Reset in the second stall cycle aborts the stall and clears the counters.
        cur = idle();
        cur.memRd = 1; cur.idRd = 8; cur.ifRs = 8;
        applyStimulus(cur);
        cur = idle();
        cur.rst = 1;
        applyStimulus(cur);
        checkOutput("rstmid.A.stall_pc", 64'(ifA.o_stall_pc), 64'd1);
        cur.rst = 0;
        applyStimulus(cur);
        checkOutput("rstafter.A.stall_pc", 64'(ifA.o_stall_pc), 64'd0);
        checkOutput("rstafter.A.stall_cycles", 64'(ifA.o_stall_cycles), 64'd0);
        checkOutput("rstafter.B.stall_cycles", 64'(ifB.o_stall_cycles), 64'd0);

        // Reset asserted while a hazard is present: first stall cycle still shows.
        cur = idle();
        cur.rst = 1; cur.memRd = 1; cur.idRd = 2; cur.ifRs = 2;
        applyStimulus(cur);
        cur.rst = 0;
        cur = idle();
        applyStimulus(cur);

        // Continuous hazard: 3-bit counter of B saturates at 7 instead of wrapping.
        cur = idle();
        cur.rst = 1;
        applyStimulus(cur);
        cur = idle();
        cur.memRd = 1; cur.idRd = 10; cur.ifRs = 10;
        for (int i = 0; i < 11; i++) applyStimulus(cur);
        cur = idle();
        applyStimulus(cur);
        checkOutput("sat.B.stall_cycles", 64'(ifB.o_stall_cycles), 64'd7);
        checkOutput("sat.A.stall_cycles", 64'(ifA.o_stall_cycles), 64'd11);
        for (int i = 0; i < 3; i++) applyStimulus(cur);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
